hash_drbg_stream: RTL and testbench

Parametrised successor DRBG: a SP 800-90A Hash_DRBG (SHA-256, single-block messages) that returns `NUM_BLOCKS` 256-bit words per request over a valid/ready stream. It reseeds itself through an entropy request/valid handshake instead of requiring an external reset. It shares a SHA-256 core with other masters through a request/grant port rather than tri-stated buses, and sits between the video scrambler key path and the shared SHA core.

---
 rtl/hash_drbg_pkg.sv | 40 ++++
 rtl/hash_drbg_stream_sha_port.sv | 59 +++++
 rtl/hash_drbg_stream.sv | 139 +++++++++++++
 tb/tb_hash_drbg_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_drbg_pkg.sv
// Shared constants, state encodings and SHA-256 single-block padding helpers
// for the Hash_DRBG stream generator.
package hash_drbg_pkg;

  localparam int BLOCKSIZE = 512;
  localparam int SEEDLEN   = 256;
  localparam int NBIT_SIZE = 64;
  localparam int PERS_LEN  = 191;

  localparam logic [7:0] PREPEND_C = 8'h00;
  localparam logic [7:0] PREPEND_H = 8'h03;

  localparam logic [63:0] LEN_SEED    = 64'd447;
  localparam logic [63:0] LEN_PREPEND = 64'd264;
  localparam logic [63:0] LEN_V       = 64'd256;

  typedef enum logic [2:0] {
    ENT_WAIT, INST_V, INST_C, IDLE, GEN_WORD, GEN_OUT, GEN_H, UPDATE
  } drbg_state_t;

  typedef enum logic [1:0] {
    P_IDLE, P_REQ, P_INIT, P_WAIT
  } port_state_t;

  // 447-bit seed message leaves room for only the marker bit, no zero fill.
  function automatic logic [BLOCKSIZE-1:0] pad_seed(input logic [SEEDLEN-1:0] e,
                                                    input logic [PERS_LEN-1:0] pers);
    return {e, pers, 1'b1, LEN_SEED};
  endfunction

  function automatic logic [BLOCKSIZE-1:0] pad_prepend(input logic [7:0] b,
                                                       input logic [SEEDLEN-1:0] v);
    return {b, v, 1'b1, 183'd0, LEN_PREPEND};
  endfunction

  function automatic logic [BLOCKSIZE-1:0] pad_v(input logic [SEEDLEN-1:0] v);
    return {v, 1'b1, 191'd0, LEN_V};
  endfunction

endpackage

// File: rtl/hash_drbg_stream_sha_port.sv
// Request/grant front end to a shared SHA-256 core: latches one message block,
// arbitrates, issues a single init pulse and captures the next digest.
module hash_drbg_sha_port
  import hash_drbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BLOCKSIZE-1:0] msg,
  output logic                 done,
  output logic [SEEDLEN-1:0]   digest,
  output logic                 sha_req,
  input  logic                 sha_grant,
  output logic                 sha_init,
  output logic [BLOCKSIZE-1:0] sha_block,
  input  logic                 sha_ready,
  input  logic [SEEDLEN-1:0]   sha_digest,
  input  logic                 sha_digest_valid
);

  port_state_t          r_state;
  port_state_t          w_state_next;
  logic [BLOCKSIZE-1:0] r_block;
  logic [SEEDLEN-1:0]   r_digest;
  logic                 r_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      P_IDLE:  if (start) w_state_next = P_REQ;
      P_REQ:   if (sha_grant && sha_ready) w_state_next = P_INIT;
      P_INIT:  w_state_next = P_WAIT;
      P_WAIT:  if (sha_digest_valid) w_state_next = P_IDLE;
      default: w_state_next = P_IDLE;
    endcase
  end

  // Digests seen outside P_WAIT belong to someone else (or a pre-reset job).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= P_IDLE;
      r_block  <= '0;
      r_digest <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == P_WAIT) && sha_digest_valid;
      if (r_state == P_IDLE && start) r_block <= msg;
      if (r_state == P_WAIT && sha_digest_valid) r_digest <= sha_digest;
    end
  end

  assign sha_req   = (r_state != P_IDLE);
  assign sha_init  = (r_state == P_INIT);
  assign sha_block = r_block;
  assign done      = r_done;
  assign digest    = r_digest;

endmodule

// File: rtl/hash_drbg_stream.sv
// SHA-256 Hash_DRBG producing NUM_BLOCKS words per request over a valid/ready
// stream, self-reseeding through an entropy handshake.
module hash_drbg_stream
  import hash_drbg_pkg::*;
#(
  parameter int unsigned           NUM_BLOCKS      = 4,
  parameter int unsigned           RESEED_INTERVAL = 37500,
  parameter logic [PERS_LEN-1:0]   PERS_STRING     = 191'h1E95B49C757C476AD85EA4A86FFD9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 entropy_req,
  input  logic                 entropy_valid,
  input  logic [SEEDLEN-1:0]   entropy,
  output logic                 ready,
  input  logic                 gen_start,
  output logic [SEEDLEN-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [NBIT_SIZE-1:0] reseed_count,
  output logic                 sha_req,
  input  logic                 sha_grant,
  output logic                 sha_init,
  output logic [BLOCKSIZE-1:0] sha_block,
  input  logic                 sha_ready,
  input  logic [SEEDLEN-1:0]   sha_digest,
  input  logic                 sha_digest_valid
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_BLOCKS - 1);

  drbg_state_t          r_state;
  drbg_state_t          w_state_next;
  logic [SEEDLEN-1:0]   r_v, r_c, r_h, r_out;
  logic [NBIT_SIZE-1:0] r_count;
  logic [4:0]           r_idx;
  logic                 r_entropy_req;
  logic                 w_start, w_done, w_ent_hs;
  logic [BLOCKSIZE-1:0] w_msg;
  logic [SEEDLEN-1:0]   w_digest;

  assign w_ent_hs = r_entropy_req && entropy_valid;

  // Each hash is launched on the transition into its waiting state.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_msg        = pad_v(r_v);
    case (r_state)
      ENT_WAIT: if (w_ent_hs) begin
        w_start      = 1'b1;
        w_msg        = pad_seed(entropy ^ r_v, PERS_STRING);
        w_state_next = INST_V;
      end
      INST_V: if (w_done) begin
        w_start      = 1'b1;
        w_msg        = pad_prepend(PREPEND_C, w_digest);
        w_state_next = INST_C;
      end
      INST_C: if (w_done) w_state_next = IDLE;
      IDLE: if (gen_start) begin
        w_start      = 1'b1;
        w_msg        = pad_v(r_v);
        w_state_next = GEN_WORD;
      end
      GEN_WORD: if (w_done) w_state_next = GEN_OUT;
      GEN_OUT: if (out_ready) begin
        w_start = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_msg        = pad_prepend(PREPEND_H, r_v);
          w_state_next = GEN_H;
        end else begin
          w_msg        = pad_v(r_v + SEEDLEN'(r_idx) + SEEDLEN'(1));
          w_state_next = GEN_WORD;
        end
      end
      GEN_H: if (w_done) w_state_next = UPDATE;
      UPDATE: w_state_next = (r_count + 64'd1 == 64'(RESEED_INTERVAL)) ? ENT_WAIT : IDLE;
      default: w_state_next = ENT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ENT_WAIT;
      r_v           <= '0;
      r_c           <= '0;
      r_h           <= '0;
      r_out         <= '0;
      r_count       <= '0;
      r_idx         <= '0;
      r_entropy_req <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_entropy_req <= (w_state_next == ENT_WAIT);
      case (r_state)
        INST_V:   if (w_done) r_v <= w_digest;
        INST_C:   if (w_done) begin
          r_c     <= w_digest;
          r_count <= '0;
        end
        IDLE:     if (gen_start) r_idx <= '0;
        GEN_WORD: if (w_done) r_out <= w_digest;
        GEN_OUT:  if (out_ready && r_idx != LAST_IDX) r_idx <= r_idx + 5'd1;
        GEN_H:    if (w_done) r_h <= w_digest;
        UPDATE: begin
          r_v     <= r_v + r_h + r_c + SEEDLEN'(r_count);
          r_count <= r_count + 64'd1;
        end
        default: ;
      endcase
    end
  end

  hash_drbg_sha_port u_sha_port (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (w_start),
    .msg              (w_msg),
    .done             (w_done),
    .digest           (w_digest),
    .sha_req          (sha_req),
    .sha_grant        (sha_grant),
    .sha_init         (sha_init),
    .sha_block        (sha_block),
    .sha_ready        (sha_ready),
    .sha_digest       (sha_digest),
    .sha_digest_valid (sha_digest_valid)
  );

  assign entropy_req  = r_entropy_req;
  assign ready        = (r_state == IDLE);
  assign out_valid    = (r_state == GEN_OUT);
  assign out_last     = (r_state == GEN_OUT) && (r_idx == LAST_IDX);
  assign out_data     = r_out;
  assign reseed_count = r_count;

endmodule

// File: tb/tb_hash_drbg_stream.sv
// Directed bench for hash_drbg_stream against a fixed-latency mock hash core
// and a straight-line software model of the DRBG.
module tb_hash_drbg_stream;

  localparam int NB = 4;
  localparam int RI = 2;
  localparam logic [190:0] PERS = 191'h1E95B49C757C476AD85EA4A86FFD9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0, entropy_valid = 1'b0, gen_start = 1'b0;
  logic         out_ready = 1'b0, sha_grant = 1'b1;
  logic [255:0] entropy = '0;
  logic         entropy_req, ready, out_valid, out_last, sha_req, sha_init, sha_ready;
  logic [255:0] out_data;
  logic [63:0]  reseed_count;
  logic [511:0] sha_block;
  logic [255:0] sha_digest = '0;
  logic         sha_digest_valid = 1'b0;

  hash_drbg_stream #(.NUM_BLOCKS(NB), .RESEED_INTERVAL(RI), .PERS_STRING(PERS)) dut (
    .clk(clk), .reset_n(reset_n), .entropy_req(entropy_req), .entropy_valid(entropy_valid),
    .entropy(entropy), .ready(ready), .gen_start(gen_start), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .reseed_count(reseed_count), .sha_req(sha_req), .sha_grant(sha_grant),
    .sha_init(sha_init), .sha_block(sha_block), .sha_ready(sha_ready),
    .sha_digest(sha_digest), .sha_digest_valid(sha_digest_valid)
  );

  // Stand-in hash: cheap, but every block bit reaches the digest.
  function automatic logic [255:0] mh(input logic [511:0] b);
    return (b[511:256] ^ {b[254:0], b[255]}) + 256'h0123456789ABCDEF_FEDCBA9876543210;
  endfunction

  // Mock core: 65-cycle latency, not affected by the DUT reset.
  logic         mock_busy = 1'b0;
  int           mock_cnt = 0;
  logic [511:0] mock_blk = '0;
  logic [511:0] blk_log[$];
  logic         init_prev = 1'b0;
  int           dbl_init = 0;
  assign sha_ready = ~mock_busy;

  always @(posedge clk) begin
    sha_digest_valid <= 1'b0;
    init_prev <= sha_init;
    if (sha_init && init_prev) dbl_init <= dbl_init + 1;
    if (mock_busy) begin
      if (mock_cnt == 1) begin
        mock_busy        <= 1'b0;
        sha_digest_valid <= 1'b1;
        sha_digest       <= mh(mock_blk);
      end
      mock_cnt <= mock_cnt - 1;
    end else if (sha_init) begin
      mock_busy <= 1'b1;
      mock_cnt  <= 65;
      mock_blk  <= sha_block;
      blk_log.push_back(sha_block);
    end
  end

  // Software model of the DRBG.
  typedef struct {
    int           gen;
    int           stall;
    bit           hold;
    logic [255:0] data;
    bit           last;
  } vec_t;
  vec_t         tv[16];
  logic [255:0] mv, mc;
  logic [63:0]  mcnt;
  logic [511:0] exp_seed[3], exp_prep[3];

  function automatic logic [511:0] m_seed(input logic [255:0] e);
    return {e, PERS, 1'b1, 64'd447};
  endfunction
  function automatic logic [511:0] m_prep(input logic [7:0] b, input logic [255:0] v);
    return {b, v, 1'b1, 183'd0, 64'd264};
  endfunction
  function automatic logic [511:0] m_pv(input logic [255:0] v);
    return {v, 1'b1, 191'd0, 64'd256};
  endfunction

  task automatic m_inst(input int k, input logic [255:0] e);
    exp_seed[k] = m_seed(e ^ mv);
    mv = mh(exp_seed[k]);
    exp_prep[k] = m_prep(8'h00, mv);
    mc = mh(exp_prep[k]);
    mcnt = '0;
  endtask

  task automatic m_gen(input int g, input int stall_word, input int stall_len, input int hold_word);
    logic [255:0] h;
    for (int i = 0; i < NB; i++) begin
      tv[g*NB+i].gen   = g;
      tv[g*NB+i].data  = mh(m_pv(mv + 256'(i)));
      tv[g*NB+i].last  = (i == NB - 1);
      tv[g*NB+i].stall = (i == stall_word) ? stall_len : 0;
      tv[g*NB+i].hold  = (i == hold_word);
    end
    h = mh(m_prep(8'h03, mv));
    mv = mv + h + mc + 256'(mcnt);
    mcnt = mcnt + 64'd1;
  endtask

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ready;
      1:       return out_valid;
      2:       return entropy_req;
      default: return sha_init;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string name, input int budget);
    int k = 0;
    while (sig(sel) !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(name, 512'(sig(sel)), 512'(1));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_flags_count"},
        512'({entropy_req, ready, out_valid, out_last, sha_req, sha_init, reseed_count}), '0);
    chk({tag, "_out_data"}, 512'(out_data), '0);
    chk({tag, "_sha_block"}, sha_block, '0);
  endtask

  task automatic supply_entropy(input logic [255:0] e);
    entropy = e;
    entropy_valid = 1'b1;
    wait_sig(2, "entropy_req_wait", 1000);
    tick();
    entropy_valid = 1'b0;
    $display("entropy handshake: %h", e);
    chk("entropy_req_fall", 512'(entropy_req), '0);
    chk("sha_req_after_entropy", 512'(sha_req), 512'(1));
  endtask

  task automatic chk_log(input int k);
    int n = blk_log.size();
    chk($sformatf("inst%0d_log_size", k), 512'(n >= 2), 512'(1));
    if (n >= 2) begin
      chk($sformatf("inst%0d_seed_block", k), blk_log[n-2], exp_seed[k]);
      chk($sformatf("inst%0d_c_block", k), blk_log[n-1], exp_prep[k]);
    end
  endtask

  task automatic run_gen(input int g);
    logic [511:0] blk0;
    wait_sig(0, $sformatf("g%0d_ready", g), 1000);
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    chk($sformatf("g%0d_ready_drop", g), 512'(ready), '0);
    for (int i = 0; i < 16; i++) begin
      if (tv[i].gen != g) continue;
      wait_sig(1, $sformatf("g%0d_w%0d_valid", g, i % NB), 1000);
      $display("gen %0d word %0d data=%h last=%b", g, i % NB, out_data, out_last);
      chk($sformatf("g%0d_w%0d_data", g, i % NB), 512'(out_data), 512'(tv[i].data));
      chk($sformatf("g%0d_w%0d_last", g, i % NB), 512'(out_last), 512'(tv[i].last));
      for (int k = 0; k < tv[i].stall; k++) begin
        tick();
        chk($sformatf("g%0d_w%0d_stall", g, i % NB), 512'({out_valid, sha_req, out_data}),
            512'({1'b1, 1'b0, tv[i].data}));
      end
      if (tv[i].hold) sha_grant = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("g%0d_w%0d_valid_fall", g, i % NB), 512'(out_valid), '0);
      if (tv[i].hold) begin
        blk0 = sha_block;
        chk("hold_req_raised", 512'(sha_req), 512'(1));
        for (int k = 0; k < 30; k++) begin
          tick();
          chk("hold_no_init", {sha_init, sha_req, sha_block}, {1'b0, 1'b1, blk0});
        end
        sha_grant = 1'b1;
      end
    end
  endtask

  initial begin
    // Expected values for every generate in the run.
    mv = '0; mc = '0; mcnt = '0;
    m_inst(0, 256'h1);
    m_gen(0, 1, 50, -1);
    m_gen(1, -1, 0, 1);
    m_inst(1, 256'hFF);
    m_gen(2, -1, 0, -1);
    mv = '0; mc = '0; mcnt = '0;
    m_inst(2, 256'h2);
    m_gen(3, 3, 7, -1);

    reset_n = 1'b0;
    repeat (3) tick();
    chk_rst("reset");
    reset_n = 1'b1;
    tick();
    chk("entropy_req_after_release", 512'(entropy_req), 512'(1));
    chk("ready_in_ent_wait", 512'(ready), '0);

    supply_entropy(256'h1);
    wait_sig(0, "inst0_ready", 1000);
    chk("inst0_count", 512'(reseed_count), '0);
    chk_log(0);

    entropy = 256'hABCD;
    entropy_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    entropy_valid = 1'b0;
    out_ready = 1'b0;
    chk("idle_ignores_stray_inputs", 512'({ready, entropy_req, out_valid, sha_req}), 512'(4'b1000));

    run_gen(0);
    wait_sig(0, "g0_back_idle", 1000);
    chk("g0_count", 512'(reseed_count), 512'(1));
    chk("g0_no_reseed", 512'(entropy_req), '0);

    run_gen(1);
    wait_sig(2, "reseed_request", 1000);
    chk("reseed_not_ready", 512'(ready), '0);
    chk("g1_count", 512'(reseed_count), 512'(2));

    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    tick();
    chk("gen_start_in_ent_wait", 512'({ready, sha_req, out_valid, entropy_req}), 512'(4'b0001));

    supply_entropy(256'hFF);
    wait_sig(0, "inst1_ready", 1000);
    chk("inst1_count", 512'(reseed_count), '0);
    chk_log(1);

    run_gen(2);
    wait_sig(0, "g2_back_idle", 1000);
    chk("g2_count", 512'(reseed_count), 512'(1));

    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
    wait_sig(3, "abort_init_seen", 100);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    chk_rst("mid_reset");
    reset_n = 1'b1;
    tick();
    chk("entropy_req_after_mid_reset", 512'(entropy_req), 512'(1));

    supply_entropy(256'h2);
    wait_sig(0, "inst2_ready", 1000);
    chk("inst2_count", 512'(reseed_count), '0);
    chk_log(2);

    run_gen(3);
    wait_sig(0, "g3_back_idle", 1000);
    chk("g3_count", 512'(reseed_count), 512'(1));
    chk("single_cycle_init", 512'(dbl_init), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
